// File: rtl/dc_out_cal.sv
// dc_out_cal: per-channel gain/intercept calibration of DC offset words into saturated DAC codes.
// Define DC_SLEW_EN to add per-lane slew limiting of the output code (slew_step per valid pass).
module dc_out_cal #(
    parameter int NUM_CH    = 2,
    parameter int IN_W      = 16,
    parameter int DAC_W     = 12,
    parameter int SLOPE_W   = 16,
    parameter int CAL_SCALE = 11,
    parameter int IN_SHIFT  = 3,
    parameter int STEP_W    = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH*IN_W-1:0]    dc_ofs,
    input  logic [NUM_CH*SLOPE_W-1:0] slope,
    input  logic [NUM_CH*DAC_W-1:0]   intercept,
    input  logic                      clip_clr,
    input  logic [STEP_W-1:0]         slew_step,
    output logic [NUM_CH*DAC_W-1:0]   dac_word,
    output logic                      dac_valid,
    output logic [NUM_CH-1:0]         clip
);
    localparam int PROD_W = IN_W + SLOPE_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] MID_S = SUM_W'(2 ** (DAC_W - 1));
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((2 ** DAC_W) - 1);
    localparam logic [DAC_W-1:0] MID_CODE = {1'b1, {(DAC_W - 1){1'b0}}};
`ifdef DC_SLEW_EN
    localparam int CW = (DAC_W > STEP_W) ? DAC_W : STEP_W;
`endif

    // Pass-valid chain; the pipeline advances on these, independent of tick spacing.
    logic v1_reg, v2_reg, v3_reg, dac_valid_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            v3_reg        <= 1'b0;
            dac_valid_reg <= 1'b0;
        end else begin
            v1_reg        <= sample_tick;
            v2_reg        <= v1_reg;
            v3_reg        <= v2_reg;
            dac_valid_reg <= v3_reg;
        end
    end

    assign dac_valid = dac_valid_reg;

`ifndef DC_SLEW_EN
    logic unused_slew;
    assign unused_slew = ^slew_step;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic signed [IN_W-1:0]    s1_reg;
            logic signed [SLOPE_W-1:0] slope1_reg;
            logic signed [DAC_W-1:0]   icpt1_reg, icpt2_reg;
            logic                      en1_reg, en2_reg, en3_reg;
            logic signed [PROD_W-1:0]  p2_reg;
            logic [DAC_W-1:0]          tgt3_reg;
            logic                      sat3_reg;
            logic [DAC_W-1:0]          code_reg;
            logic                      clip_reg;
            logic signed [PROD_W-1:0]  g;
            logic signed [SUM_W-1:0]   u;
            logic [DAC_W-1:0]          tgt_next;
            logic                      sat_next;
            logic [DAC_W-1:0]          code_next;

            // Calibrated code at one bit of headroom over the product, then clamp.
            always_comb begin
                g        = p2_reg >>> CAL_SCALE;
                u        = {g[PROD_W-1], g}
                         + {{(SUM_W - DAC_W){icpt2_reg[DAC_W-1]}}, icpt2_reg}
                         + MID_S;
                tgt_next = u[DAC_W-1:0];
                sat_next = 1'b0;
                if (u[SUM_W-1]) begin
                    tgt_next = '0;
                    sat_next = 1'b1;
                end else if (u > MAX_S) begin
                    tgt_next = '1;
                    sat_next = 1'b1;
                end
            end

`ifdef DC_SLEW_EN
            logic [CW-1:0] diff_w;
            logic [CW-1:0] step_w;

            // A zero step means unlimited; otherwise move at most step toward the target.
            always_comb begin
                step_w    = CW'(slew_step);
                diff_w    = (tgt3_reg >= code_reg) ? CW'(tgt3_reg - code_reg)
                                                   : CW'(code_reg - tgt3_reg);
                code_next = tgt3_reg;
                if (step_w != '0 && diff_w > step_w) begin
                    if (tgt3_reg > code_reg)
                        code_next = code_reg + step_w[DAC_W-1:0];
                    else
                        code_next = code_reg - step_w[DAC_W-1:0];
                end
            end
`else
            always_comb begin
                code_next = tgt3_reg;
            end
`endif

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_reg     <= '0;
                    slope1_reg <= '0;
                    icpt1_reg  <= '0;
                    icpt2_reg  <= '0;
                    en1_reg    <= 1'b0;
                    en2_reg    <= 1'b0;
                    en3_reg    <= 1'b0;
                    p2_reg     <= '0;
                    tgt3_reg   <= MID_CODE;
                    sat3_reg   <= 1'b0;
                    code_reg   <= MID_CODE;
                    clip_reg   <= 1'b0;
                end else begin
                    if (sample_tick) begin
                        s1_reg     <= $signed(dc_ofs[gi*IN_W +: IN_W]) >>> IN_SHIFT;
                        slope1_reg <= $signed(slope[gi*SLOPE_W +: SLOPE_W]);
                        icpt1_reg  <= $signed(intercept[gi*DAC_W +: DAC_W]);
                        en1_reg    <= enable[gi];
                    end
                    if (v1_reg) begin
                        p2_reg    <= PROD_W'(s1_reg) * PROD_W'(slope1_reg);
                        icpt2_reg <= icpt1_reg;
                        en2_reg   <= en1_reg;
                    end
                    if (v2_reg) begin
                        tgt3_reg <= tgt_next;
                        sat3_reg <= sat_next;
                        en3_reg  <= en2_reg;
                    end
                    if (v3_reg && en3_reg)
                        code_reg <= code_next;
                    // A new saturation event overrides a simultaneous clear.
                    clip_reg <= (clip_reg & ~clip_clr) | (v3_reg & en3_reg & sat3_reg);
                end
            end

            assign dac_word[gi*DAC_W +: DAC_W] = code_reg;
            assign clip[gi]                    = clip_reg;
        end
    endgenerate
endmodule

// File: tb/tb_dc_out_cal.sv
// Randomised scoreboard bench for dc_out_cal: stimulus pushes expected targets, a monitor pops on dac_valid.
// Compile with +define+DC_SLEW_EN to exercise the slew-limited build.
module tb_dc_out_cal;
    localparam int NUM_CH = 2;
    localparam int MID    = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [1:0]  enable;
    logic [31:0] dc_ofs;
    logic [31:0] slope;
    logic [23:0] intercept;
    logic        clip_clr;
    logic [11:0] slew_step;
    logic [23:0] dac_word;
    logic        dac_valid;
    logic [1:0]  clip;

    dc_out_cal dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .enable     (enable),
        .dc_ofs     (dc_ofs),
        .slope      (slope),
        .intercept  (intercept),
        .clip_clr   (clip_clr),
        .slew_step  (slew_step),
        .dac_word   (dac_word),
        .dac_valid  (dac_valid),
        .clip       (clip)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         issue;
        logic [1:0] en;
        int         tgt0;
        int         tgt1;
        logic [1:0] sat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m_code[NUM_CH];
    logic [1:0] m_clip;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int lane(input int c);
        return int'(dac_word[c*12 +: 12]);
    endfunction

    // Reference: floor(floor(ofs/8) * slope / 2^11) + intercept + 2048, clamped to [0, 4095].
    function automatic int ref_target(input int ofs, input int slp, input int icpt, output bit sat);
        longint s, p, u;
        s = longint'(ofs) >>> 3;
        p = s * longint'(slp);
        u = (p >>> 11) + longint'(icpt) + 2048;
        sat = 1'b0;
        if (u < 0) begin
            sat = 1'b1;
            return 0;
        end
        if (u > 4095) begin
            sat = 1'b1;
            return 4095;
        end
        return int'(u);
    endfunction

    function automatic int move(input int cur, input int tgt, input int step);
`ifdef DC_SLEW_EN
        if (step == 0) return tgt;
        if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
        return (cur - tgt > step) ? cur - step : tgt;
`else
        if (step < 0) return cur;
        return tgt;
`endif
    endfunction

    task automatic issue(input logic [1:0] en, input int o0, input int o1,
                         input int sl0, input int sl1, input int ic0, input int ic1);
        exp_t e;
        bit   s0, s1;
        @(negedge clk);
        enable      = en;
        dc_ofs      = {16'(o1), 16'(o0)};
        slope       = {16'(sl1), 16'(sl0)};
        intercept   = {12'(ic1), 12'(ic0)};
        sample_tick = 1'b1;
        e.issue = cyc;
        e.en    = en;
        e.tgt0  = ref_target(o0, sl0, ic0, s0);
        e.tgt1  = ref_target(o1, sl1, ic1, s1);
        e.sat   = {s1, s0};
        sb.push_back(e);
    endtask

    // Idle cycles scramble the data inputs, which must not leak into any pass.
    task automatic idle(input int n, input bit rand_clr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            dc_ofs      = $urandom;
            slope       = $urandom;
            intercept   = 24'($urandom);
            enable      = 2'($urandom);
            clip_clr    = rand_clr ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            idle(1, 1'b0);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
        idle(1, 1'b0);
    endtask

    task automatic tick_one(input logic [1:0] en, input int o0, input int o1,
                            input int sl0, input int sl1, input int ic0, input int ic1);
        issue(en, o0, o1, sl0, sl1, ic0, ic1);
        drain();
    endtask

    // Monitor: applies the model on each output pulse and compares against it.
    always @(posedge clk) begin
        logic       clr_s;
        int         step_s;
        exp_t       e;
        cyc++;
        clr_s  = clip_clr;
        step_s = int'(slew_step);
        #1;
        if (reset) begin
            sb.delete();
            for (int c = 0; c < NUM_CH; c++) m_code[c] = MID;
            m_clip = 2'b00;
            check("valid_in_reset", int'(dac_valid), 0);
        end else begin
            if (clr_s) m_clip = 2'b00;
            if (dac_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc - e.issue, 4);
                    if (e.en[0]) begin
                        m_code[0] = move(m_code[0], e.tgt0, step_s);
                        if (e.sat[0]) m_clip[0] = 1'b1;
                    end
                    if (e.en[1]) begin
                        m_code[1] = move(m_code[1], e.tgt1, step_s);
                        if (e.sat[1]) m_clip[1] = 1'b1;
                    end
                    check("lane0_code", lane(0), m_code[0]);
                    check("lane1_code", lane(1), m_code[1]);
                    check("clip_flags", int'(clip), int'(m_clip));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sample_tick = 1'b0; enable = 2'b00; dc_ofs = '0; slope = '0;
        intercept = '0; clip_clr = 1'b0; slew_step = '0;
        for (int c = 0; c < NUM_CH; c++) m_code[c] = MID;
        m_clip = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_lane0", lane(0), MID);
        check("reset_lane1", lane(1), MID);
        check("reset_clip", int'(clip), 0);
        check("reset_valid", int'(dac_valid), 0);

        tick_one(2'b11, 0, 0, 1961, 1961, 24, 24);
        check("t1_lane0", lane(0), 2072);
        check("t1_lane1", lane(1), 2072);

        tick_one(2'b11, 8192, -16384, 1961, 1961, 24, 24);
        check("t2_lane0", lane(0), 3052);
        check("t2_lane1", lane(1), 111);
        check("t2_clip", int'(clip), 0);

        tick_one(2'b11, 32767, 0, 4096, 1961, 24, 24);
        check("t3_sat_hi", lane(0), 4095);
        check("t3_clip_set", int'(clip), 1);
        tick_one(2'b11, -32768, 0, 4096, 1961, 24, 24);
        check("t3_sat_lo", lane(0), 0);
        check("t3_clip_sticky", int'(clip), 1);
        issue(2'b11, 32767, 0, 4096, 1961, 24, 24);
        idle(2, 1'b0);
        @(negedge clk);
        sample_tick = 1'b0;
        clip_clr    = 1'b1;
        drain();
        check("t3_set_wins", int'(clip), 1);
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        check("t3_clip_clr", int'(clip), 0);

        tick_one(2'b11, 0, 0, 1961, 1961, 24, 24);
        tick_one(2'b01, 8192, 8192, 1961, 1961, 24, 24);
        check("t4_lane0_upd", lane(0), 3052);
        check("t4_lane1_hold", lane(1), 2072);

        issue(2'b11, 8192, 0, 1961, 1961, 24, 24);
        issue(2'b11, -16384, 8192, 1961, 1961, 24, 24);
        issue(2'b11, 0, -16384, 1961, 1961, 24, 24);
        drain();
        check("t5_lane0", lane(0), 2072);
        check("t5_lane1", lane(1), 111);

        issue(2'b11, 8192, 8192, 1961, 1961, 24, 24);
        issue(2'b11, 8192, 8192, 1961, 1961, 24, 24);
        @(negedge clk);
        sample_tick = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        reset       = 1'b0;
        idle(10, 1'b0);
        check("t5_rst_lane0", lane(0), MID);
        check("t5_rst_lane1", lane(1), MID);
        check("t5_rst_clip", int'(clip), 0);

`ifdef DC_SLEW_EN
        tick_one(2'b11, 0, 0, 1961, 1961, 24, 24);
        slew_step = 12'd100;
        for (int i = 1; i <= 10; i++) begin
            tick_one(2'b11, 8192, 0, 1961, 1961, 24, 24);
            check("t6_slew_step", lane(0), (i < 10) ? 2072 + 100 * i : 3052);
        end
        slew_step = 12'd0;
        tick_one(2'b11, 0, 0, 1961, 1961, 24, 24);
        tick_one(2'b11, 8192, 0, 1961, 1961, 24, 24);
        check("t6_slew_zero", lane(0), 3052);
`endif

        for (int n = 0; n < 150; n++) begin
            logic [15:0] r0, r1, q0, q1;
            logic [11:0] c0, c1;
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            q0 = 16'($urandom);
            q1 = 16'($urandom);
            c0 = 12'($urandom);
            c1 = 12'($urandom);
            if (n % 2 == 0) begin
                r0 = 16'($signed(r0) >>> 4);
                r1 = 16'($signed(r1) >>> 4);
            end
            slew_step = 12'($urandom_range(0, 300));
            issue(2'($urandom), int'($signed(r0)), int'($signed(r1)),
                  int'($signed(q0)), int'($signed(q1)), int'($signed(c0)), int'($signed(c1)));
            idle($urandom_range(0, 3), 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
